// File: rtl/axis_guv_multi_pkg.sv
// rtl/axis_guv_multi_pkg.sv - shared cmd-bus fields, register map, control/mode types
// Contents: register indices, response tag, CTRL/mode struct, output-select enum,
//   status-word packer used by the STATUS_RD response.
package axis_guv_multi_pkg;

  // Register indices carried in cmd word bits [19:16].
  localparam logic [3:0] REG_CTRL      = 4'd0;
  localparam logic [3:0] REG_INJ_SHIFT = 4'd1;
  localparam logic [3:0] REG_INJ_GO    = 4'd2;
  localparam logic [3:0] REG_STATUS_RD = 4'd3;
  localparam logic [3:0] REG_LOG_CLR   = 4'd4;

  // Tag placed in the reg field of a status response.
  localparam logic [3:0] RESP_TAG = 4'hF;

  // CTRL register layout; the same struct holds the latched per-packet mode.
  typedef struct packed {
    logic log_en;
    logic drop;
    logic pause;
  } ctrl_t;

  // Output-path selection, in priority order inject > drop > pause > pass.
  typedef enum logic [1:0] {
    SEL_PASS,
    SEL_PAUSE,
    SEL_DROP,
    SEL_INJECT
  } sel_e;

  function automatic logic [31:0] status_word(
    input logic [11:0] id,
    input logic [7:0]  ovf,
    input logic        pend,
    input logic        in_pkt,
    input logic [5:0]  occ
  );
    return {id, RESP_TAG, ovf, pend, in_pkt, occ};
  endfunction

endpackage

// File: rtl/axis_guv_multi_log_fifo.sv
// rtl/axis_guv_multi_log_fifo.sv - synchronous log FIFO with clear, occupancy, full/empty
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               flush; wins over a same-cycle push or pop
//   push_tdata/tvalid write side; a push is taken when not full or popping this cycle
//   pop_tdata/tready  read side; pop_tdata is the head entry, valid whenever !empty
//   full, empty       status flags
//   count             occupancy, 0..2**DEPTH_W
module guv_log_fifo #(
  parameter int WIDTH   = 33,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [WIDTH-1:0]   push_tdata,
  input  logic               push_tvalid,
  output logic [WIDTH-1:0]   pop_tdata,
  input  logic               pop_tready,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W:0]   count
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == (DEPTH_W + 1)'(DEPTH));
  assign empty = (count == '0);

  // Head is read straight out of storage: an entry written this cycle only
  // becomes visible next cycle, so there is no fall-through path.
  assign pop_tdata = mem[rd_ptr];

  assign do_pop  = !empty && pop_tready;
  assign do_push = push_tvalid && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_W + 1)'(1);
        2'b01:   count <= count - (DEPTH_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr] <= push_tdata;
  end

endmodule

// File: rtl/axis_guv_multi.sv
// rtl/axis_guv_multi.sv - stream governor: pass/pause/drop/inject on din->dout, input log, cmd-bus control
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   din_TDATA/TVALID/TLAST/TREADY     governed input stream
//   dout_TDATA/TVALID/TLAST/TREADY    governed output stream (pass mode is combinational)
//   cmd_in_TDATA/TVALID               daisy-chained command bus in, {id[11:0], reg[3:0], val[15:0]}
//   cmd_out_TDATA/TVALID              forwarded command words and status responses, 1-cycle latency
//   log_TDATA/TLAST/TVALID/TREADY     log of accepted input flits
module axis_guv_multi
  import axis_guv_multi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LOG_DEPTH_W = 4,
  parameter int ID_WIDTH    = 12,
  parameter int GUV_ID      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_TDATA,
  input  logic                  din_TVALID,
  input  logic                  din_TLAST,
  output logic                  din_TREADY,
  output logic [DATA_WIDTH-1:0] dout_TDATA,
  output logic                  dout_TVALID,
  output logic                  dout_TLAST,
  input  logic                  dout_TREADY,
  input  logic [31:0]           cmd_in_TDATA,
  input  logic                  cmd_in_TVALID,
  output logic [31:0]           cmd_out_TDATA,
  output logic                  cmd_out_TVALID,
  output logic [DATA_WIDTH-1:0] log_TDATA,
  output logic                  log_TLAST,
  output logic                  log_TVALID,
  input  logic                  log_TREADY
);

  localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(GUV_ID);

  // Command decode
  logic [11:0] cmd_id;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_val;
  logic        cmd_hit;
  logic        wr_ctrl;
  logic        wr_shift;
  logic        wr_go;
  logic        rd_status;
  logic        log_clr;

  assign cmd_id  = cmd_in_TDATA[31:20];
  assign cmd_reg = cmd_in_TDATA[19:16];
  assign cmd_val = cmd_in_TDATA[15:0];

  assign cmd_hit   = cmd_in_TVALID && (cmd_id == MY_ID);
  assign wr_ctrl   = cmd_hit && (cmd_reg == REG_CTRL);
  assign wr_shift  = cmd_hit && (cmd_reg == REG_INJ_SHIFT);
  assign wr_go     = cmd_hit && (cmd_reg == REG_INJ_GO);
  assign rd_status = cmd_hit && (cmd_reg == REG_STATUS_RD);
  assign log_clr   = cmd_hit && (cmd_reg == REG_LOG_CLR);

  // State
  ctrl_t                 ctrl_q;
  ctrl_t                 mode_q;
  ctrl_t                 eff;
  logic                  in_pkt;
  logic [DATA_WIDTH-1:0] inj_data;
  logic                  inj_last;
  logic                  inject_pending;
  logic [7:0]            ovf_cnt;
  sel_e                  sel;

  // 16-bit words enter at the top and older words move down.
  logic [DATA_WIDTH+15:0] shift_cat;
  assign shift_cat = {cmd_val, inj_data};

  // Mode is frozen for the duration of an input packet; CTRL changes only
  // take hold when no packet is in flight.
  always_comb begin
    eff = in_pkt ? mode_q : ctrl_q;
  end

  always_comb begin
    if (inject_pending && !in_pkt) sel = SEL_INJECT;
    else if (eff.drop)             sel = SEL_DROP;
    else if (eff.pause)            sel = SEL_PAUSE;
    else                           sel = SEL_PASS;
  end

  always_comb begin
    dout_TDATA  = din_TDATA;
    dout_TLAST  = din_TLAST;
    dout_TVALID = 1'b0;
    din_TREADY  = 1'b0;
    case (sel)
      SEL_PASS: begin
        dout_TVALID = din_TVALID;
        din_TREADY  = dout_TREADY;
      end
      SEL_DROP: begin
        din_TREADY = 1'b1;
      end
      SEL_INJECT: begin
        dout_TDATA  = inj_data;
        dout_TLAST  = inj_last;
        dout_TVALID = 1'b1;
      end
      default: begin
      end
    endcase
    // Pass mode is combinational, so hold the handshakes low while in reset.
    if (rst) begin
      dout_TVALID = 1'b0;
      din_TREADY  = 1'b0;
    end
  end

  logic din_hs;
  logic inj_hs;
  assign din_hs = din_TVALID && din_TREADY;
  assign inj_hs = (sel == SEL_INJECT) && dout_TREADY && !rst;

  // Log FIFO
  logic                   log_push;
  logic                   log_pop;
  logic                   log_full;
  logic                   log_empty;
  logic                   ovf_evt;
  logic [LOG_DEPTH_W:0]   log_count;
  logic [DATA_WIDTH:0]    log_head;
  logic [31:0]            occ_wide;
  logic [5:0]             occ6;

  assign log_push = din_hs && eff.log_en;
  assign log_pop  = !log_empty && log_TREADY;
  // A clear swallows a coincident push without counting it as an overflow.
  assign ovf_evt  = log_push && log_full && !log_pop && !log_clr;

  guv_log_fifo #(
    .WIDTH   (DATA_WIDTH + 1),
    .DEPTH_W (LOG_DEPTH_W)
  ) u_log_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr         (log_clr),
    .push_tdata  ({din_TDATA, din_TLAST}),
    .push_tvalid (log_push),
    .pop_tdata   (log_head),
    .pop_tready  (log_TREADY),
    .full        (log_full),
    .empty       (log_empty),
    .count       (log_count)
  );

  assign log_TDATA  = log_head[DATA_WIDTH:1];
  assign log_TLAST  = log_head[0];
  assign log_TVALID = !log_empty && !rst;

  always_comb begin
    occ_wide = 32'(log_count);
    occ6     = (occ_wide > 32'd63) ? 6'd63 : occ_wide[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q         <= '0;
      mode_q         <= '0;
      in_pkt         <= 1'b0;
      inj_data       <= '0;
      inj_last       <= 1'b0;
      inject_pending <= 1'b0;
      ovf_cnt        <= '0;
      cmd_out_TDATA  <= '0;
      cmd_out_TVALID <= 1'b0;
    end else begin
      mode_q <= eff;

      if (din_hs) in_pkt <= !din_TLAST;

      if (wr_ctrl) ctrl_q <= ctrl_t'(cmd_val[2:0]);

      if (wr_shift && !inject_pending) inj_data <= shift_cat[DATA_WIDTH+15:16];

      if (inj_hs) begin
        inject_pending <= 1'b0;
      end else if (wr_go && !inject_pending) begin
        inject_pending <= 1'b1;
        inj_last       <= cmd_val[0];
      end

      // A status read reports and clears the counter; an overflow in the
      // same cycle is kept so it shows up in the next read.
      if (rd_status) begin
        ovf_cnt <= {7'd0, ovf_evt};
      end else if (ovf_evt && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end

      cmd_out_TVALID <= 1'b0;
      if (cmd_in_TVALID && !cmd_hit) begin
        cmd_out_TVALID <= 1'b1;
        cmd_out_TDATA  <= cmd_in_TDATA;
      end else if (rd_status) begin
        cmd_out_TVALID <= 1'b1;
        cmd_out_TDATA  <= status_word(MY_ID, ovf_cnt, inject_pending, in_pkt, occ6);
      end
    end
  end

endmodule
